// File: rtl/icache_if.sv
// Fetch-side and backing-memory signals of the direct-mapped instruction cache.
// The cache takes the slave view; the core/memory environment takes the master view.
interface icache_if;
    logic        core_req;
    logic [31:0] core_addr;
    logic [31:0] core_data;
    logic        core_stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    modport slave (
        input  core_req, core_addr, flush, mem_ack, mem_data,
        output core_data, core_stall, mem_req, mem_addr
    );

    modport master (
        output core_req, core_addr, flush, mem_ack, mem_data,
        input  core_data, core_stall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path,
// blocking word-by-word line refill from backing memory, flush-all invalidate.
//
// state  | meaning
// S_IDLE | lookup; a miss latches the line base and starts a refill
// S_FILL | one word request per ack, sequential from word 0; returns when the line is done
module icache_dm #(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input logic      clk,
    input logic      rst,
    icache_if.slave  bus
);
    localparam int WB    = $clog2(WORDS);
    localparam int OFF   = WB + 2;
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 31 - OFF - IDX;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t              state, state_nxt;
    logic [WB-1:0]       cnt;
    logic [30:OFF]       fill_base;
    logic                kill;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_array  [LINES];
    logic [31:0]         data_array [LINES][WORDS];

    logic [IDX-1:0]      req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [WB-1:0]       req_word;
    logic [IDX-1:0]      fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                hit;
    logic                fill_start;
    logic                fill_done;
    logic                word_ack;
    logic                unused_addr_bits;

    // Bit 31 (supervisor) and the byte offset play no part in lookup.
    assign unused_addr_bits = ^{bus.core_addr[31], bus.core_addr[1:0]};

    assign req_idx  = bus.core_addr[OFF+IDX-1:OFF];
    assign req_tag  = bus.core_addr[30:OFF+IDX];
    assign req_word = bus.core_addr[OFF-1:2];
    assign fill_idx = fill_base[OFF+IDX-1:OFF];
    assign fill_tag = fill_base[30:OFF+IDX];

    assign hit = bus.core_req & valid[req_idx] & (tag_array[req_idx] == req_tag)
                 & (state == S_IDLE);

    assign bus.core_data  = hit ? data_array[req_idx][req_word] : 32'h0;
    assign bus.core_stall = bus.core_req & ~hit;

    assign word_ack = (state == S_FILL) & bus.mem_ack;

    always_comb begin
        state_nxt    = state;
        fill_start   = 1'b0;
        fill_done    = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_addr = 32'h0;
        case (state)
            S_IDLE: begin
                if (bus.core_req && !hit) begin
                    state_nxt  = S_FILL;
                    fill_start = 1'b1;
                end
            end
            S_FILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {1'b0, fill_base, cnt, 2'b00};
                if (bus.mem_ack && cnt == WB'(WORDS - 1)) begin
                    state_nxt = S_IDLE;
                    fill_done = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            fill_base <= '0;
            kill      <= 1'b0;
            valid     <= '0;
        end else begin
            state <= state_nxt;

            if (fill_start) begin
                fill_base <= bus.core_addr[30:OFF];
                cnt       <= '0;
            end else if (word_ack) begin
                cnt <= cnt + WB'(1);
            end

            // A flush landing on the final ack still leaves the line invalid.
            if (bus.flush)
                valid <= '0;
            else if (fill_done && !kill)
                valid[fill_idx] <= 1'b1;

            if (fill_done)
                kill <= 1'b0;
            else if (state == S_FILL && bus.flush)
                kill <= 1'b1;
        end
    end

    // Storage arrays carry no reset; writes are gated off while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && word_ack)
            data_array[fill_idx][cnt] <= bus.mem_data;
        if (!rst && fill_done)
            tag_array[fill_idx] <= fill_tag;
    end
endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: a line-level cache model checked every cycle at negedge,
// plus directed fetch scenarios with hand-computed stall counts, data and addresses.
module tb_icache_dm;
    logic clk = 1'b0;
    logic rst;

    icache_if bus ();

    icache_dm #(.LINES(64), .WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int ack_mode = 0;      // 0: ack always high; 1: ack on every 3rd fill cycle
    int gap      = 0;
    logic ack_bad = 1'b0;  // memory returns a poison word instead of the image

    // Memory image: line 0x100 reads 0xA0..0xA3, other lines differ in the upper byte.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (((a >> 4) ^ 32'h10) << 8) + 32'hA0 + {30'b0, a[3:2]};
    endfunction

    assign bus.mem_data = ack_bad ? 32'hDEADBEEF : mem_fn(bus.mem_addr);

    always @(posedge clk) begin
        #2;
        if (ack_mode == 0) begin
            bus.mem_ack = 1'b1;
        end else if (bus.mem_req) begin
            bus.mem_ack = (gap == 2);
            gap = (gap == 2) ? 0 : gap + 1;
        end else begin
            bus.mem_ack = 1'b0;
            gap = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line-level model ----------------
    bit          m_known = 0;
    bit          m_busy  = 0;
    bit          m_kill  = 0;
    logic [31:0] m_base  = 0;
    int          m_done  = 0;
    bit          m_valid [64];
    logic [31:0] m_line  [64];
    logic [31:0] m_data  [64][4];

    always @(negedge clk) begin
        logic [31:0] a, line, e_data, e_addr, val;
        int idx, w;
        bit e_hit, e_stall;
        a    = bus.core_addr;
        line = {1'b0, a[30:4], 4'b0};
        idx  = int'(a[9:4]);
        w    = int'(a[3:2]);
        e_hit   = bus.core_req && !m_busy && m_valid[idx] && (m_line[idx] == line);
        e_stall = bus.core_req && !e_hit;
        e_data  = e_hit ? m_data[idx][w] : 32'h0;
        e_addr  = m_busy ? m_base + 32'(4 * m_done) : 32'h0;
        if (m_known) begin
            chk("core_stall", {31'b0, bus.core_stall}, {31'b0, e_stall});
            chk("core_data",  bus.core_data, e_data);
            chk("mem_req",    {31'b0, bus.mem_req}, {31'b0, m_busy});
            chk("mem_addr",   bus.mem_addr, e_addr);
        end
        if (rst) begin
            m_known = 1;
            m_busy  = 0;
            m_kill  = 0;
            foreach (m_valid[i]) m_valid[i] = 0;
        end else if (m_busy) begin
            if (bus.flush) begin
                foreach (m_valid[i]) m_valid[i] = 0;
                m_kill = 1;
            end
            if (bus.mem_ack) begin
                val = ack_bad ? 32'hDEADBEEF : mem_fn(e_addr);
                m_data[int'(m_base[9:4])][m_done] = val;
                m_done++;
                if (m_done == 4) begin
                    m_busy = 0;
                    if (!m_kill && !bus.flush) begin
                        m_valid[int'(m_base[9:4])] = 1;
                        m_line[int'(m_base[9:4])]  = m_base;
                    end
                    m_kill = 0;
                end
            end
        end else begin
            if (bus.flush) foreach (m_valid[i]) m_valid[i] = 0;
            if (e_stall) begin
                m_busy = 1;
                m_base = line;
                m_done = 0;
                m_kill = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] ack_addrs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input int flush_at,
                         output int stalls, output logic [31:0] data, output int nreq);
        bus.core_req  = 1'b1;
        bus.core_addr = a;
        stalls = 0;
        nreq   = 0;
        data   = 32'h0;
        ack_addrs.delete();
        forever begin
            bus.flush = (stalls == flush_at);
            @(negedge clk);
            if (bus.mem_req) nreq++;
            if (bus.mem_req && bus.mem_ack) ack_addrs.push_back(bus.mem_addr);
            if (!bus.core_stall) begin
                data = bus.core_data;
                break;
            end
            stalls++;
            if (stalls > 200) begin
                total++;
                bad++;
                $display("FAIL fetch_timeout addr=%h stalls=%0d required<=200", a, stalls);
                break;
            end
            tick();
        end
        tick();
        bus.core_req = 1'b0;
        bus.flush    = 1'b0;
    endtask

    function automatic logic [31:0] ack_at(input int i);
        return (ack_addrs.size() > i) ? ack_addrs[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, nr;
        logic [31:0] d;
        rst = 1'b1;
        bus.core_req  = 1'b0;
        bus.core_addr = 32'h0;
        bus.flush     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        @(negedge clk);
        chk("rst_stall", {31'b0, bus.core_stall}, 32'h0);
        chk("rst_data",  bus.core_data, 32'h0);
        chk("rst_mreq",  {31'b0, bus.mem_req}, 32'h0);
        chk("rst_maddr", bus.mem_addr, 32'h0);
        tick();

        // Cold miss, 1+WORDS stall, sequential word addresses.
        fetch(32'h0000_0100, -1, st, d, nr);
        chk("miss_stall", st, 5);
        chk("miss_data",  d, 32'hA0);
        chk("miss_nacks", ack_addrs.size(), 4);
        for (int i = 0; i < 4; i++) chk("miss_addr", ack_at(i), 32'h100 + 32'(4 * i));

        fetch(32'h0000_0108, -1, st, d, nr);
        chk("hit_stall", st, 0);
        chk("hit_data",  d, 32'hA2);
        chk("hit_nreq",  nr, 0);

        fetch(32'h8000_0100, -1, st, d, nr);
        chk("sup_stall", st, 0);
        chk("sup_data",  d, 32'hA0);
        chk("sup_nreq",  nr, 0);

        // Conflict at index 0x10 evicts and reloads.
        fetch(32'h0000_0500, -1, st, d, nr);
        chk("conf_stall", st, 5);
        chk("conf_data",  d, 32'h40A0);
        chk("conf_addr0", ack_at(0), 32'h500);
        fetch(32'h0000_0100, -1, st, d, nr);
        chk("evict_stall", st, 5);
        chk("evict_data",  d, 32'hA0);
        chk("evict_addr0", ack_at(0), 32'h100);

        // Ack only every third fill cycle.
        ack_mode = 1;
        fetch(32'h0000_0200, -1, st, d, nr);
        chk("gap_stall", st, 13);
        chk("gap_data",  d, 32'h30A0);
        chk("gap_nreq",  nr, 12);
        for (int i = 0; i < 4; i++) chk("gap_addr", ack_at(i), 32'h200 + 32'(4 * i));
        for (int i = 1; i < 4; i++) begin
            fetch(32'h0000_0200 + 32'(4 * i), -1, st, d, nr);
            chk("gap_word_stall", st, 0);
            chk("gap_word_data",  d, 32'h30A0 + 32'(i));
        end
        ack_mode = 0;

        // Flush in the 2nd fill cycle: fill completes but stays invalid, refetch refills.
        fetch(32'h0000_0300, 2, st, d, nr);
        chk("kill_stall", st, 10);
        chk("kill_nacks", ack_addrs.size(), 8);
        chk("kill_refill_addr", ack_at(4), 32'h300);
        chk("kill_data",  d, 32'h20A0);

        // Flush in IDLE alongside a hit: hit served, next fetch misses.
        fetch(32'h0000_0304, 0, st, d, nr);
        chk("iflush_stall", st, 0);
        chk("iflush_data",  d, 32'h20A1);
        fetch(32'h0000_0304, -1, st, d, nr);
        chk("iflush_miss_stall", st, 5);
        chk("iflush_miss_data",  d, 32'h20A1);
        chk("iflush_addr0", ack_at(0), 32'h300);

        // Reset after two acks of a refill of 0x100.
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.core_req  = 1'b1;
        bus.core_addr = 32'h0000_0100;
        tick();
        tick();
        tick();
        rst = 1'b1;
        bus.core_req = 1'b0;
        ack_bad = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstfill_mreq",  {31'b0, bus.mem_req}, 32'h0);
        chk("rstfill_stall", {31'b0, bus.core_stall}, 32'h0);
        tick();
        ack_bad = 1'b0;
        fetch(32'h0000_0100, -1, st, d, nr);
        chk("rstfill_refill_stall", st, 5);
        chk("rstfill_refill_addr0", ack_at(0), 32'h100);
        chk("rstfill_refill_data",  d, 32'hA0);
        fetch(32'h0000_010C, -1, st, d, nr);
        chk("rstfill_word3", d, 32'hA3);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the core's instruction-fetch port and a slower backing memory.
- On a hit, returns the instruction word combinationally in the same cycle.
- On a miss, stalls the fetch stage, refills one full line word-by-word through a req/ack handshake, then releases the stall.
- A flush input invalidates all lines, for self-modifying code and loader use.

Parameters:
- LINES, 64, number of cache lines; power of 2, ≥2.
- WORDS, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- core_req  input  1  fetch valid this cycle
- core_addr  input  32  fetch byte address; bit 31 = supervisor bit
- core_data  output  32  instruction word
- core_stall  output  1  fetch must hold core_addr and retry
- flush  input  1  invalidate all lines
- mem_req  output  1  backing-memory word read request
- mem_addr  output  32  backing-memory word address, bits [1:0] = 0
- mem_ack  input  1  mem_data valid; request accepted
- mem_data  input  32  backing-memory read data

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Address split:
  - OFF = log2(WORDS)+2; IDX = log2(LINES).
  - Word select = addr[OFF-1:2]; index = addr[OFF+IDX-1:OFF]; tag = addr[30:OFF+IDX].
  - Bit 31 is ignored (supervisor and user alias the same line). Bits [1:0] are ignored.
- Storage:
  - Data array: LINES×WORDS×32. Tag array: LINES×tag width. Valid: LINES bits.
  - All arrays read combinationally.
- hit = core_req & valid[index] & (tag_array[index] == tag) & (state == IDLE).
- core_data = selected word when hit, else 32'h0.
- core_stall = core_req & ~hit. It is combinational, with no registered latency on hits.
- FSM states:
  - IDLE: on core_req & ~hit, latch line base (addr[30:OFF], bit 31 cleared, offset zeroed) into fill_base. Clear word counter cnt. Go to FILL.
  - FILL:
    - mem_req = 1; mem_addr = fill_base + cnt*4.
    - On mem_ack: write mem_data to data_array[index][cnt] and increment cnt.
    - On the ack with cnt == WORDS-1: write tag, set valid (unless killed), go to IDLE.
    - mem_addr and mem_req hold steady until ack; no word is skipped or repeated.
- Miss timing with mem_ack tied high:
  - Miss cycle plus WORDS fill cycles stall the core: 1+WORDS cycles.
  - The hit is served in the next cycle.
  - With ack gaps, the stall extends by exactly the gap cycles.
- Fill order: sequential from word 0. No critical-word-first, no early restart.
- core_addr changed during FILL:
  - Illegal for the core, but defined: the fill completes for the latched line.
  - Lookup then re-evaluates the current core_addr in IDLE.
- Flush:
  - In IDLE: all valid bits are cleared at the clock edge. A same-cycle hit is still served, from pre-flush state.
  - In FILL: all valid bits are cleared and a kill flag is set. The fill runs to completion so the memory handshake is never abandoned. On completion, valid is not set for that line. The kill flag clears on return to IDLE.
  - Back-to-back flushes are harmless.
- core_req = 0 in IDLE: no state change, core_stall = 0, core_data = 0.
- Reset:
  - state = IDLE, cnt = 0, all valid = 0, kill = 0, mem_req = 0, mem_addr = 0.
  - core_stall = 0 and core_data = 0 while no hit.
  - Tag and data arrays are not reset.
  - Reset asserted mid-fill: mem_req drops in the cycle after the reset edge. Partial line data is left invalid. A late mem_ack after reset is ignored in IDLE.
- mem_ack while mem_req = 0: ignored.

Test Plan:
- (LINES=64, WORDS=4) Reset, core_req=1, core_addr=0x00000100, mem_ack always 1 with data 0xA0,0xA1,0xA2,0xA3 → core_stall=1 for 5 cycles; mem_addr sequence 0x100,0x104,0x108,0x10C; cycle 5: core_stall=0, core_data=0xA0. Then addr 0x108 → same-cycle core_data=0xA2, mem_req stays 0.
- Conflict: after filling 0x100, fetch 0x500 (same index 0x10) → miss and refill. Then fetch 0x100 → miss again (evicted), mem_addr restarts at 0x100.
- Ack gaps: mem_ack high only every 3rd cycle of FILL → mem_addr held between acks, total stall 1+12 cycles, words stored in order.
- Flush mid-fill: pulse flush in the 2nd FILL cycle → fill completes (4 acks). The following fetch of the same address misses and refills. Flush in IDLE after a fill → next fetch misses.
- Supervisor alias: fill 0x00000100, then fetch 0x80000100 → hit, data 0xA0, no mem_req.
- Reset mid-fill: assert rst after 2 acks → mem_req=0 the next cycle, core_stall=0, no write to valid. Re-fetch of 0x100 misses and restarts at 0x100. An extra mem_ack pulse after reset causes no array write.
